memory_access_unit: RTL and testbench
=====================================

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XLEN, 32, data/address width; only 32 is legal.
- RD_W, 5, destination-register index width.
- TIMEOUT, 16, maximum wait cycles for mem_ack, minimum 2.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1 clock
- rst in 1 asynchronous active-high reset
- valid_in in 1 stage input valid
- alu_result_in in XLEN effective address / ALU value
- flag_zero_in in 1 ALU zero flag
- add_sum_in in XLEN branch target
- rs2_data_in in XLEN store data
- rd_in in RD_W destination index
- funct3_in in 3 size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- mem_read_ctl, mem_write_ctl, branch_ctl in 1 each, control
- mem_rdata in XLEN controller read data
- mem_ack in 1 controller completion
- read_data_out out XLEN aligned, extended load data
- alu_result_out out XLEN; add_sum_out out XLEN; rd_out out RD_W
- pcsrc_out out 1 branch taken
- valid_out out 1 output valid
- stall_out out 1 freeze upstream stages
- mem_req, mem_we out 1 each
- mem_addr out XLEN; mem_wdata out XLEN; mem_be out 4
- fault_out out 2 (01 misaligned, 10 timeout)

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS, WAIT_DRAIN; it SHALL leave IDLE only when valid_in and (mem_read_ctl or mem_write_ctl).
REQ-004 A non-memory op SHALL appear on the registered outputs one cycle after valid_in, with pcsrc_out = flag_zero_in & branch_ctl and stall_out low.
REQ-005 In ACCESS, mem_req, mem_we (= mem_write_ctl), mem_addr (word-aligned), mem_wdata and mem_be SHALL be held constant until mem_ack is sampled high.
REQ-006 stall_out SHALL be combinationally high in ACCESS and in the IDLE cycle that accepts a memory op, and low otherwise.
REQ-007 On mem_ack the unit SHALL register the load data and assert valid_out for exactly one cycle on the next edge, then return to IDLE.
REQ-008 Store data SHALL be replicated into byte lanes: SB gives mem_be = 0001 << addr[1:0], SH gives 0011 << addr[1:0], SW gives 1111. A load SHALL drive mem_be = 1111.
REQ-009 Loads SHALL select the lane at addr[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU) to XLEN.
REQ-010 A wait counter SHALL reset on ACCESS entry; reaching TIMEOUT without mem_ack SHALL drop mem_req, set fault_out = 10, pulse valid_out and enter WAIT_DRAIN.
REQ-011 WAIT_DRAIN SHALL ignore one late mem_ack and return to IDLE after one cycle.
REQ-012 mem_read_ctl and mem_write_ctl both high SHALL be treated as a store.
REQ-013 A mem_ack arriving in the same cycle the counter hits TIMEOUT SHALL complete normally, with no fault.
REQ-014 fault_out SHALL be valid only while valid_out is high and 00 otherwise.

Reset
REQ-015 rst high SHALL immediately force: state IDLE; mem_req, mem_we, stall_out, valid_out, pcsrc_out low; all data outputs, mem_be, fault_out and the counter zero.
REQ-016 A reset during ACCESS SHALL abandon the transaction; a mem_ack arriving after reset is released SHALL be ignored in IDLE.

Configuration
REQ-017 Macro MAU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=00, SHALL not issue mem_req; the unit SHALL pulse valid_out with fault_out = 01 one cycle later.
REQ-018 Macro MAU_MISALIGN_TRAP_EN undefined: offending low address bits SHALL be cleared before access, and fault_out[0] SHALL be tied 0.

Structure
REQ-019 Package mau_pkg SHALL hold the funct3 size constants, the FSM state enum, the fault codes and the mem_be lane-mask function.
REQ-020 Sub-module load_align SHALL perform combinational lane selection and sign/zero extension.

Verification
REQ-021 The bench SHALL cover:
- Non-memory op with branch_ctl=1, flag_zero_in=1, add_sum_in=0x100 -> next cycle pcsrc_out=1, add_sum_out=0x100, stall_out=0.
- LB at addr 0x1003, mem_rdata=0x80FF_FF7F, ack after 3 cycles -> read_data_out=0xFFFF_FF80, stall_out high 4 cycles.
- SH at addr 0x2002, rs2_data_in=0x1234_ABCD -> mem_be=1100, mem_wdata[31:16]=0xABCD, mem_addr=0x2000.
- No ack for TIMEOUT=16 cycles -> mem_req drops, fault_out=10; a late ack in WAIT_DRAIN is ignored.
- LW at addr 0x3001 with MAU_MISALIGN_TRAP_EN -> no mem_req, fault_out=01; without the macro -> access at 0x3000.
- rst asserted mid-ACCESS -> all outputs zero in the same cycle, FSM in IDLE.

Source files
------------

// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg -- shared definitions for the memory access unit.
//   * funct3 size/sign constants and access size encodings
//   * FSM state enum
//   * fault codes reported on fault_out
//   * byte-lane mask, misalignment and address-clearing helpers
// -----------------------------------------------------------------------------
package mau_pkg;

    // funct3 encodings (the store encodings SB/SH/SW share the low two bits)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size taken from funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ACCESS     = 2'b01,
        ST_WAIT_DRAIN = 2'b10
    } state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    // Byte-enable mask for a store of the given size at the given lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
            SZ_HALF: lane_mask = 4'b0011 << addr_lo;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // True when the low address bits break natural alignment for the size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

    // Low address bits with the offending ones cleared for the size.
    function automatic logic [1:0] align_lo(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: align_lo = addr_lo;
            SZ_HALF: align_lo = {addr_lo[1], 1'b0};
            default: align_lo = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_unit_load_align.sv
// -----------------------------------------------------------------------------
// load_align -- combinational load lane selection and sign/zero extension.
// Ports:
//   rdata_i   : raw word returned by the memory controller
//   addr_lo_i : byte offset of the access within the word
//   funct3_i  : load type (LB/LH/LW/LBU/LHU)
//   data_o    : aligned, extended load result
// -----------------------------------------------------------------------------
module load_align
    import mau_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[8*addr_lo_i +: 8];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit -- MEM pipeline stage with a handshaked memory port.
// Non-memory ops pass through in one cycle; loads/stores issue a request that
// is held until mem_ack or a wait timeout, freezing upstream via stall_out.
// Ports:
//   clk, rst (async, active high)
//   valid_in, alu_result_in, flag_zero_in, add_sum_in, rs2_data_in, rd_in,
//   funct3_in, mem_read_ctl, mem_write_ctl, branch_ctl : stage inputs
//   mem_rdata, mem_ack                        : controller response
//   read_data_out, alu_result_out, add_sum_out, rd_out, pcsrc_out,
//   valid_out, fault_out                      : registered stage outputs
//   stall_out                                 : combinational upstream freeze
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be : controller request
// Build option: define MAU_MISALIGN_TRAP_EN to trap misaligned accesses with
// fault_out = 01 instead of silently clearing the offending address bits.
// -----------------------------------------------------------------------------
module memory_access_unit
    import mau_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic            flag_zero_in,
    input  logic [XLEN-1:0] add_sum_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [RD_W-1:0] rd_in,
    input  logic [2:0]      funct3_in,
    input  logic            mem_read_ctl,
    input  logic            mem_write_ctl,
    input  logic            branch_ctl,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] read_data_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] add_sum_out,
    output logic [RD_W-1:0] rd_out,
    output logic            pcsrc_out,
    output logic            valid_out,
    output logic            stall_out,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    output logic [1:0]      fault_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]   read_data_q, read_data_d, alu_q, alu_d, add_sum_q, add_sum_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [1:0]        addr_lo_q, addr_lo_d, fault_q, fault_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              valid_q, valid_d, pcsrc_q, pcsrc_d, stall_c;
    logic [XLEN-1:0]   load_data, wdata_rep;
    logic [1:0]        size, eff_lo;

    assign size   = funct3_in[1:0];
    assign eff_lo = align_lo(size, alu_result_in[1:0]);

`ifdef MAU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = is_misaligned(size, alu_result_in[1:0]);
`endif

    // Store data replicated into every lane so mem_be alone picks the bytes.
    always_comb begin
        case (size)
            SZ_BYTE: wdata_rep = {4{rs2_data_in[7:0]}};
            SZ_HALF: wdata_rep = {2{rs2_data_in[15:0]}};
            default: wdata_rep = rs2_data_in;
        endcase
    end

    // Lane select uses the latched offset/type: mem_rdata arrives in ACCESS.
    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i   (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .data_o    (load_data)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        read_data_d = read_data_q;
        alu_d       = alu_q;
        add_sum_d   = add_sum_q;
        rd_d        = rd_q;
        valid_d     = 1'b0;
        pcsrc_d     = 1'b0;
        fault_d     = FAULT_NONE;
        stall_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    alu_d     = alu_result_in;
                    add_sum_d = add_sum_in;
                    rd_d      = rd_in;
                    if (!(mem_read_ctl || mem_write_ctl)) begin
                        valid_d = 1'b1;
                        pcsrc_d = flag_zero_in & branch_ctl;
                    end
`ifdef MAU_MISALIGN_TRAP_EN
                    else if (misalign) begin
                        valid_d = 1'b1;
                        fault_d = FAULT_MISALIGN;
                    end
`endif
                    else begin
                        // Write wins when both controls are set.
                        stall_c     = 1'b1;
                        state_d     = ST_ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write_ctl;
                        mem_addr_d  = {alu_result_in[XLEN-1:2], 2'b00};
                        mem_wdata_d = wdata_rep;
                        mem_be_d    = mem_write_ctl ? lane_mask(size, eff_lo) : 4'b1111;
                        addr_lo_d   = eff_lo;
                        funct3_d    = funct3_in;
                    end
                end
            end
            ST_ACCESS: begin
                stall_c = 1'b1;
                // An ack in the final counted cycle still completes normally.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    valid_d   = 1'b1;
                    if (!mem_we_q) read_data_d = load_data;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    valid_d   = 1'b1;
                    fault_d   = FAULT_TIMEOUT;
                    state_d   = ST_WAIT_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Swallows a late ack from the abandoned request.
            ST_WAIT_DRAIN: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            read_data_q <= '0;
            alu_q       <= '0;
            add_sum_q   <= '0;
            rd_q        <= '0;
            valid_q     <= 1'b0;
            pcsrc_q     <= 1'b0;
            fault_q     <= FAULT_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            read_data_q <= read_data_d;
            alu_q       <= alu_d;
            add_sum_q   <= add_sum_d;
            rd_q        <= rd_d;
            valid_q     <= valid_d;
            pcsrc_q     <= pcsrc_d;
            fault_q     <= fault_d;
        end
    end

    // Reset gating keeps stall low even if an op is presented during reset.
    assign stall_out      = stall_c & ~rst;
    assign read_data_out  = read_data_q;
    assign alu_result_out = alu_q;
    assign add_sum_out    = add_sum_q;
    assign rd_out         = rd_q;
    assign pcsrc_out      = pcsrc_q;
    assign valid_out      = valid_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_be         = mem_be_q;
    assign fault_out      = fault_q;

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk, rst;
    logic        valid_in, flag_zero_in, mem_read_ctl, mem_write_ctl, branch_ctl, mem_ack;
    logic [31:0] alu_result_in, add_sum_in, rs2_data_in, mem_rdata;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic [31:0] read_data_out, alu_result_out, add_sum_out, mem_addr, mem_wdata;
    logic [4:0]  rd_out;
    logic        pcsrc_out, valid_out, stall_out, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [1:0]  fault_out;

    int passed = 0;
    int total  = 0;

    memory_access_unit #(.XLEN(32), .RD_W(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .flag_zero_in(flag_zero_in), .add_sum_in(add_sum_in), .rs2_data_in(rs2_data_in),
        .rd_in(rd_in), .funct3_in(funct3_in), .mem_read_ctl(mem_read_ctl),
        .mem_write_ctl(mem_write_ctl), .branch_ctl(branch_ctl), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .add_sum_out(add_sum_out), .rd_out(rd_out), .pcsrc_out(pcsrc_out),
        .valid_out(valid_out), .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .fault_out(fault_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [175:0] all_outputs();
        return {read_data_out, alu_result_out, add_sum_out, rd_out, pcsrc_out, valid_out,
                stall_out, mem_req, mem_we, mem_addr, mem_wdata, mem_be, fault_out};
    endfunction

    task automatic clear_inputs();
        valid_in = 0; flag_zero_in = 0; mem_read_ctl = 0; mem_write_ctl = 0;
        branch_ctl = 0; alu_result_in = 0; add_sum_in = 0; rs2_data_in = 0;
        rd_in = 0; funct3_in = 0;
    endtask

    // Drives one memory op at a negedge, acks it in ACCESS cycle ack_cycle and
    // returns what was seen on the request port and at completion.
    task automatic run_mem(input logic [31:0] addr, input logic [2:0] f3,
                           input logic rd_c, input logic wr_c,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ack_cycle,
                           output logic req1, output logic we1, output logic [31:0] addr1,
                           output logic [31:0] wdata1, output logic [3:0] be1,
                           output logic vld, output logic [31:0] data,
                           output logic [1:0] flt, output int stalls);
        stalls = 0;
        valid_in = 1; alu_result_in = addr; funct3_in = f3; rd_in = 5'd9;
        mem_read_ctl = rd_c; mem_write_ctl = wr_c; rs2_data_in = wdata;
        #1 if (stall_out) stalls++;
        @(negedge clk);
        clear_inputs();
        req1 = mem_req; we1 = mem_we; addr1 = mem_addr; wdata1 = mem_wdata; be1 = mem_be;
        for (int c = 1; c < ack_cycle; c++) begin
            #1 if (stall_out) stalls++;
            @(negedge clk);
        end
        mem_ack = 1; mem_rdata = rdata;
        #1 if (stall_out) stalls++;
        @(negedge clk);
        mem_ack = 0;
        vld = valid_out; data = read_data_out; flt = fault_out;
        #1 if (stall_out) stalls++;
    endtask

    logic        r_req, r_we, r_vld;
    logic [31:0] r_addr, r_wdata, r_data;
    logic [3:0]  r_be;
    logic [1:0]  r_flt;
    int          r_stalls;

    task automatic test_reset();
        rst = 1; clear_inputs(); mem_ack = 0; mem_rdata = 0;
        #2;
        total++; if (all_outputs() !== '0) $display("FAIL reset_outputs: got %h want 0", all_outputs()); else passed++;
        @(negedge clk);
        total++; if (all_outputs() !== '0) $display("FAIL reset_held: got %h want 0", all_outputs()); else passed++;
        rst = 0;
    endtask

    task automatic test_nonmem();
        @(negedge clk);
        valid_in = 1; branch_ctl = 1; flag_zero_in = 1; add_sum_in = 32'h100;
        alu_result_in = 32'h55; rd_in = 5'd7;
        #1;
        total++; if (stall_out !== 1'b0) $display("FAIL nonmem_stall_accept: got %b want 0", stall_out); else passed++;
        @(negedge clk);
        clear_inputs();
        total++; if (valid_out !== 1'b1) $display("FAIL nonmem_valid: got %b want 1", valid_out); else passed++;
        total++; if (pcsrc_out !== 1'b1) $display("FAIL nonmem_pcsrc: got %b want 1", pcsrc_out); else passed++;
        total++; if (add_sum_out !== 32'h100) $display("FAIL nonmem_add_sum: got %h want 00000100", add_sum_out); else passed++;
        total++; if (alu_result_out !== 32'h55) $display("FAIL nonmem_alu: got %h want 00000055", alu_result_out); else passed++;
        total++; if (rd_out !== 5'd7) $display("FAIL nonmem_rd: got %0d want 7", rd_out); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL nonmem_no_req: got %b want 0", mem_req); else passed++;
        valid_in = 1; branch_ctl = 1; flag_zero_in = 0;
        @(negedge clk);
        clear_inputs();
        total++; if ({valid_out, pcsrc_out} !== 2'b10) $display("FAIL nonmem_not_taken: got %b want 10", {valid_out, pcsrc_out}); else passed++;
        @(negedge clk);
        total++; if (valid_out !== 1'b0) $display("FAIL nonmem_pulse: got %b want 0", valid_out); else passed++;
    endtask

    task automatic test_load();
        @(negedge clk);
        run_mem(32'h1003, 3'b000, 1, 0, 0, 32'h80FF_FF7F, 3,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if ({r_req, r_we} !== 2'b10) $display("FAIL lb_req_we: got %b want 10", {r_req, r_we}); else passed++;
        total++; if (r_addr !== 32'h1000) $display("FAIL lb_addr: got %h want 00001000", r_addr); else passed++;
        total++; if (r_be !== 4'b1111) $display("FAIL lb_be: got %b want 1111", r_be); else passed++;
        total++; if ({r_vld, r_flt} !== 3'b100) $display("FAIL lb_valid_fault: got %b want 100", {r_vld, r_flt}); else passed++;
        total++; if (r_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", r_data); else passed++;
        total++; if (r_stalls !== 4) $display("FAIL lb_stall_cycles: got %0d want 4", r_stalls); else passed++;
        total++; if (rd_out !== 5'd9) $display("FAIL lb_rd: got %0d want 9", rd_out); else passed++;
        @(negedge clk);
        total++; if (valid_out !== 1'b0) $display("FAIL lb_pulse: got %b want 0", valid_out); else passed++;
        run_mem(32'h1003, 3'b100, 1, 0, 0, 32'h80FF_FF7F, 1,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if (r_data !== 32'h0000_0080) $display("FAIL lbu_data: got %h want 00000080", r_data); else passed++;
        total++; if (r_stalls !== 2) $display("FAIL lbu_stall_cycles: got %0d want 2", r_stalls); else passed++;
        @(negedge clk);
        run_mem(32'h1002, 3'b001, 1, 0, 0, 32'h8001_0000, 2,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if (r_data !== 32'hFFFF_8001) $display("FAIL lh_data: got %h want ffff8001", r_data); else passed++;
        @(negedge clk);
        run_mem(32'h1000, 3'b101, 1, 0, 0, 32'h1234_F00D, 1,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if (r_data !== 32'h0000_F00D) $display("FAIL lhu_data: got %h want 0000f00d", r_data); else passed++;
        @(negedge clk);
        run_mem(32'h1001, 3'b000, 1, 0, 0, 32'h0000_7F00, 1,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if (r_data !== 32'h0000_007F) $display("FAIL lb_pos_data: got %h want 0000007f", r_data); else passed++;
    endtask

    task automatic test_store();
        @(negedge clk);
        run_mem(32'h2002, 3'b001, 0, 1, 32'h1234_ABCD, 0, 1,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if ({r_req, r_we} !== 2'b11) $display("FAIL sh_req_we: got %b want 11", {r_req, r_we}); else passed++;
        total++; if (r_be !== 4'b1100) $display("FAIL sh_be: got %b want 1100", r_be); else passed++;
        total++; if (r_wdata[31:16] !== 16'hABCD) $display("FAIL sh_wdata_hi: got %h want abcd", r_wdata[31:16]); else passed++;
        total++; if (r_addr !== 32'h2000) $display("FAIL sh_addr: got %h want 00002000", r_addr); else passed++;
        total++; if ({r_vld, r_flt} !== 3'b100) $display("FAIL sh_complete: got %b want 100", {r_vld, r_flt}); else passed++;
        total++; if ({mem_req, mem_we} !== 2'b00) $display("FAIL sh_req_drop: got %b want 00", {mem_req, mem_we}); else passed++;
        @(negedge clk);
        // Read and write controls both set: must be a byte store.
        run_mem(32'h4001, 3'b000, 1, 1, 32'h0000_00A5, 0, 2,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if (r_we !== 1'b1) $display("FAIL both_ctl_we: got %b want 1", r_we); else passed++;
        total++; if (r_be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", r_be); else passed++;
        total++; if (r_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", r_wdata); else passed++;
        @(negedge clk);
        run_mem(32'h4004, 3'b010, 0, 1, 32'hCAFE_F00D, 0, 1,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if ({r_be, r_wdata} !== {4'b1111, 32'hCAFE_F00D}) $display("FAIL sw_be_wdata: got %b %h want 1111 cafef00d", r_be, r_wdata); else passed++;
        total++; if (r_addr !== 32'h4004) $display("FAIL sw_addr: got %h want 00004004", r_addr); else passed++;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        @(negedge clk);
        valid_in = 1; mem_read_ctl = 1; funct3_in = 3'b010; alu_result_in = 32'h5000;
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < TIMEOUT; i++) begin
            if (mem_req) req_cycles++;
            @(negedge clk);
        end
        total++; if (req_cycles !== TIMEOUT) $display("FAIL to_req_cycles: got %0d want %0d", req_cycles, TIMEOUT); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL to_req_drop: got %b want 0", mem_req); else passed++;
        total++; if ({valid_out, fault_out} !== 3'b110) $display("FAIL to_fault: got %b want 110", {valid_out, fault_out}); else passed++;
        total++; if (stall_out !== 1'b0) $display("FAIL to_stall: got %b want 0", stall_out); else passed++;
        mem_ack = 1; mem_rdata = 32'h9999_9999;
        @(negedge clk);
        mem_ack = 0;
        total++; if ({valid_out, fault_out} !== 3'b000) $display("FAIL drain_late_ack: got %b want 000", {valid_out, fault_out}); else passed++;
        total++; if (read_data_out === 32'h9999_9999) $display("FAIL drain_data: got %h want not 99999999", read_data_out); else passed++;
        @(negedge clk);
        total++; if ({valid_out, mem_req} !== 2'b00) $display("FAIL drain_idle: got %b want 00", {valid_out, mem_req}); else passed++;
        // Ack in the last counted cycle completes normally.
        run_mem(32'h6000, 3'b010, 1, 0, 0, 32'hDEAD_BEEF, TIMEOUT,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if ({r_vld, r_flt} !== 3'b100) $display("FAIL ack_at_limit_fault: got %b want 100", {r_vld, r_flt}); else passed++;
        total++; if (r_data !== 32'hDEAD_BEEF) $display("FAIL ack_at_limit_data: got %h want deadbeef", r_data); else passed++;
        total++; if (r_stalls !== TIMEOUT + 1) $display("FAIL ack_at_limit_stalls: got %0d want %0d", r_stalls, TIMEOUT + 1); else passed++;
    endtask

    task automatic test_misalign();
        @(negedge clk);
`ifdef MAU_MISALIGN_TRAP_EN
        valid_in = 1; mem_read_ctl = 1; funct3_in = 3'b010; alu_result_in = 32'h3001;
        @(negedge clk);
        clear_inputs();
        total++; if (mem_req !== 1'b0) $display("FAIL trap_no_req: got %b want 0", mem_req); else passed++;
        total++; if ({valid_out, fault_out} !== 3'b101) $display("FAIL trap_fault: got %b want 101", {valid_out, fault_out}); else passed++;
        valid_in = 1; mem_write_ctl = 1; funct3_in = 3'b001; alu_result_in = 32'h3003;
        @(negedge clk);
        clear_inputs();
        total++; if ({mem_req, valid_out, fault_out} !== 4'b0101) $display("FAIL trap_sh: got %b want 0101", {mem_req, valid_out, fault_out}); else passed++;
        @(negedge clk);
        total++; if ({valid_out, fault_out} !== 3'b000) $display("FAIL trap_pulse: got %b want 000", {valid_out, fault_out}); else passed++;
`else
        run_mem(32'h3001, 3'b010, 1, 0, 0, 32'h1122_3344, 1,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if ({r_req, r_addr} !== {1'b1, 32'h3000}) $display("FAIL clr_lw_addr: got %b %h want 1 00003000", r_req, r_addr); else passed++;
        total++; if (r_data !== 32'h1122_3344) $display("FAIL clr_lw_data: got %h want 11223344", r_data); else passed++;
        total++; if (r_flt !== 2'b00) $display("FAIL clr_lw_fault: got %b want 00", r_flt); else passed++;
        @(negedge clk);
        run_mem(32'h2003, 3'b001, 0, 1, 32'h0000_BEEF, 0, 1,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if (r_be !== 4'b1100) $display("FAIL clr_sh_be: got %b want 1100", r_be); else passed++;
        @(negedge clk);
        run_mem(32'h7003, 3'b101, 1, 0, 0, 32'h8001_0000, 1,
                r_req, r_we, r_addr, r_wdata, r_be, r_vld, r_data, r_flt, r_stalls);
        total++; if (r_data !== 32'h0000_8001) $display("FAIL clr_lhu_data: got %h want 00008001", r_data); else passed++;
`endif
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        valid_in = 1; mem_read_ctl = 1; funct3_in = 3'b010; alu_result_in = 32'h8000; rd_in = 5'd4;
        @(negedge clk);
        clear_inputs();
        total++; if (mem_req !== 1'b1) $display("FAIL mid_in_access: got %b want 1", mem_req); else passed++;
        #2 rst = 1;
        #1;
        total++; if (all_outputs() !== '0) $display("FAIL mid_reset_outputs: got %h want 0", all_outputs()); else passed++;
        @(negedge clk);
        rst = 0; mem_ack = 1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 0;
        total++; if ({valid_out, mem_req, read_data_out} !== {2'b00, 32'h0}) $display("FAIL post_reset_ack: got %b %b %h want 0 0 00000000", valid_out, mem_req, read_data_out); else passed++;
        valid_in = 1; branch_ctl = 1; flag_zero_in = 1; add_sum_in = 32'h200;
        @(negedge clk);
        clear_inputs();
        total++; if ({valid_out, pcsrc_out, add_sum_out} !== {2'b11, 32'h200}) $display("FAIL post_reset_idle: got %b %b %h want 1 1 00000200", valid_out, pcsrc_out, add_sum_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_timeout();
        test_misalign();
        test_reset_mid_access();
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
